// File: rtl/unidade_mult_div.sv
// Iterative unsigned multiply/divide unit: radix-2 shift-add MULT and restoring DIV,
// one iteration per cycle, result held in Hi/Lo until the next accepted operation.
module unidade_mult_div #(
    parameter int WIDTH = 32
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [3:0]       ControleALU,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             DivZero
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [3:0] OP_MULT = 4'b1000;
    localparam logic [3:0] OP_DIV  = 4'b1001;

    typedef enum logic [1:0] {IDLE, MULT_RUN, DIV_RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dz_q, dz_d;

    logic               accept;
    logic [WIDTH:0]     mult_sum;
    logic [2*WIDTH:0]   mult_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH:0]   div_next;

    // acc layout: MULT = {carry, upper product, multiplier/lower product};
    // DIV = {remainder (WIDTH+1 bits), dividend/quotient}.
    always_comb begin
        accept = ((state_q == IDLE) || (state_q == DONE)) && Start &&
                 ((ControleALU == OP_MULT) || (ControleALU == OP_DIV));

        mult_sum  = acc_q[0] ? (acc_q[2*WIDTH:WIDTH] + {1'b0, opb_q})
                             : acc_q[2*WIDTH:WIDTH];
        mult_next = {1'b0, mult_sum, acc_q[WIDTH-1:1]};

        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opb_q};
        if (!div_diff[WIDTH]) begin
            div_next = {div_diff, acc_q[WIDTH-2:0], 1'b1};
        end else begin
            div_next = {div_shift, acc_q[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dz_d    = dz_q;

        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    opb_d   = B;
                    acc_d   = {{(WIDTH+1){1'b0}}, A};
                    cnt_d   = CNT_INIT;
                    dz_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = (ControleALU == OP_MULT) ? MULT_RUN : DIV_RUN;
                end else begin
                    state_d = IDLE;
                end
            end

            MULT_RUN: begin
                acc_d = mult_next;
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    hi_d    = mult_next[2*WIDTH-1:WIDTH];
                    lo_d    = mult_next[WIDTH-1:0];
                end
            end

            DIV_RUN: begin
                if (opb_q == '0) begin
                    // Divide by zero finishes immediately with a fixed result.
                    state_d = DONE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    hi_d    = acc_q[WIDTH-1:0];
                    lo_d    = '1;
                    dz_d    = 1'b1;
                end else begin
                    acc_d = div_next;
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        hi_d    = div_next[2*WIDTH-1:WIDTH];
                        lo_d    = div_next[WIDTH-1:0];
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opb_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign Busy    = busy_q;
    assign Done    = done_q;
    assign Hi      = hi_q;
    assign Lo      = lo_q;
    assign DivZero = dz_q;

endmodule

// File: tb/tb_unidade_mult_div.sv
// Scoreboard bench for unidade_mult_div: directed operations push expected results,
// a negedge monitor pops and checks them whenever Done is presented.
module tb_unidade_mult_div;

    localparam logic [3:0] OP_MULT = 4'b1000;
    localparam logic [3:0] OP_DIV  = 4'b1001;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Start;
    logic [3:0]  ControleALU;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic        Done;
    logic [31:0] Hi;
    logic [31:0] Lo;
    logic        DivZero;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          cyc;
        int          busy;
        int          busy_base;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;
    int   busy_total = 0;

    unidade_mult_div #(.WIDTH(32)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .ControleALU(ControleALU),
        .A(A), .B(B), .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo), .DivZero(DivZero)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    always @(negedge Clock) if (Busy === 1'b1) busy_total <= busy_total + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(negedge Clock) begin
        if (Done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("hi", {32'd0, Hi}, {32'd0, mon_e.hi});
                check("lo", {32'd0, Lo}, {32'd0, mon_e.lo});
                check("divzero", {63'd0, DivZero}, {63'd0, mon_e.dz});
                check("done_cycle", 64'(cyc), 64'(mon_e.cyc));
                check("busy_length", 64'(busy_total - mon_e.busy_base), 64'(mon_e.busy));
                check("busy_with_done", {63'd0, Busy}, 64'd0);
            end
        end
    end

    // Drive one accepted operation and record what the monitor must see.
    task automatic start_op(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                            input int lat);
        exp_t e;
        ControleALU = code;
        A = a;
        B = b;
        Start = 1'b1;
        @(posedge Clock);
        #1;
        Start = 1'b0;
        A = 32'hDEAD_BEEF;
        B = 32'h1234_5678;
        ControleALU = (code == OP_MULT) ? OP_DIV : OP_MULT;
        e.hi = ehi;
        e.lo = elo;
        e.dz = edz;
        e.cyc = cyc + lat;
        e.busy = lat;
        e.busy_base = busy_total;
        sb.push_back(e);
    endtask

    task automatic wait_done();
        bit got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge Clock);
            if (Done === 1'b1) got = 1'b1;
        end
        if (!got) check("done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        Reset = 1'b1;
        Start = 1'b0;
        ControleALU = 4'b0000;
        A = '0;
        B = '0;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        check("reset_busy", {63'd0, Busy}, 64'd0);
        check("reset_done", {63'd0, Done}, 64'd0);
        check("reset_hi", {32'd0, Hi}, 64'd0);
        check("reset_lo", {32'd0, Lo}, 64'd0);
        check("reset_divzero", {63'd0, DivZero}, 64'd0);
        Reset = 1'b0;
        @(negedge Clock);

        start_op(OP_MULT, 32'd3, 32'd5, 32'h0, 32'hF, 1'b0, 32);
        wait_done();
        @(negedge Clock);

        start_op(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 1'b0, 32);
        wait_done();
        @(negedge Clock);

        start_op(OP_DIV, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 32);
        wait_done();
        @(negedge Clock);

        start_op(OP_DIV, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 1);
        wait_done();
        @(negedge Clock);

        // Start while busy must be ignored; the original result and timing stand.
        start_op(OP_MULT, 32'd3, 32'd5, 32'h0, 32'd15, 1'b0, 32);
        repeat (9) @(negedge Clock);
        ControleALU = OP_MULT;
        A = 32'd2;
        B = 32'd2;
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        wait_done();
        @(negedge Clock);

        // Unsupported opcode in IDLE: nothing happens.
        ControleALU = 4'b0010;
        A = 32'd9;
        B = 32'd9;
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        repeat (5) begin
            @(negedge Clock);
            check("bad_op_busy", {63'd0, Busy}, 64'd0);
        end
        check("bad_op_hi", {32'd0, Hi}, 64'd0);
        check("bad_op_lo", {32'd0, Lo}, 64'd15);

        // Reset mid-run discards the operation and clears the result registers.
        ControleALU = OP_MULT;
        A = 32'd3;
        B = 32'd5;
        Start = 1'b1;
        @(posedge Clock);
        #1;
        Start = 1'b0;
        repeat (10) @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        check("midrst_busy", {63'd0, Busy}, 64'd0);
        check("midrst_done", {63'd0, Done}, 64'd0);
        check("midrst_hi", {32'd0, Hi}, 64'd0);
        check("midrst_lo", {32'd0, Lo}, 64'd0);
        check("midrst_divzero", {63'd0, DivZero}, 64'd0);
        Reset = 1'b0;
        repeat (40) @(negedge Clock);
        check("midrst_still_idle", {63'd0, Busy}, 64'd0);

        start_op(OP_MULT, 32'd6, 32'd7, 32'h0, 32'd42, 1'b0, 32);
        wait_done();
        @(negedge Clock);

        // Back-to-back: DIV accepted in the Done cycle of the MULT.
        start_op(OP_MULT, 32'd3, 32'd5, 32'h0, 32'd15, 1'b0, 32);
        wait_done();
        start_op(OP_DIV, 32'd9, 32'd2, 32'd1, 32'd4, 1'b0, 32);
        @(negedge Clock);
        check("b2b_busy_rise", {63'd0, Busy}, 64'd1);
        wait_done();
        @(negedge Clock);
        @(negedge Clock);

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
